// File: rtl/game_sequencer.sv
// Game-flow controller: turns VGA vsync into a frame-locked game tick and runs the
// round state machine (idle / run / crash flash / over) with level and day/night scheduling.
module game_sequencer #(
    parameter int FRAMES_INIT  = 4,
    parameter int FRAMES_MIN   = 1,
    parameter int LEVEL_TICKS  = 512,
    parameter int FLASH_FRAMES = 60,
    parameter int NIGHT_TICKS  = 1024
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       vs,
    input  logic       start,
    input  logic       jump,
    input  logic       collision,
    output logic       tick,
    output logic       running,
    output logic       game_over,
    output logic       clear,
    output logic       flash,
    output logic [2:0] level,
    output logic       night
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLASH, ST_OVER} state_t;

    localparam logic [4:0]  FI5     = 5'(FRAMES_INIT);
    localparam logic [4:0]  FM5     = 5'(FRAMES_MIN);
    localparam logic [15:0] LT_LAST = 16'(LEVEL_TICKS - 1);
    localparam logic [15:0] NT_LAST = 16'(NIGHT_TICKS - 1);
    localparam logic [7:0]  FF_LAST = 8'(FLASH_FRAMES - 1);

    state_t      state_q, state_d;
    logic        vs_meta_q, vs_sync_q, vs_hist_q;
    logic        frame_evt_q, frame_evt_d;
    logic        jump_prev_q;
    logic        jump_rise;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] night_cnt_q, night_cnt_d;
    logic [7:0]  flash_cnt_q, flash_cnt_d;
    logic [2:0]  level_q, level_d;
    logic        night_q, night_d;
    logic        flash_q, flash_d;
    logic        tick_q, tick_d;
    logic        clear_q, clear_d;
    logic        running_q, running_d;
    logic        game_over_q, game_over_d;
    logic [4:0]  level_ext;
    logic [3:0]  fpt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            vs_meta_q   <= 1'b1;
            vs_sync_q   <= 1'b1;
            vs_hist_q   <= 1'b1;
            frame_evt_q <= 1'b0;
            // A jump held through reset must not count as a fresh press.
            jump_prev_q <= 1'b1;
            frame_cnt_q <= '0;
            tick_cnt_q  <= '0;
            night_cnt_q <= '0;
            flash_cnt_q <= '0;
            level_q     <= '0;
            night_q     <= 1'b0;
            flash_q     <= 1'b0;
            tick_q      <= 1'b0;
            clear_q     <= 1'b0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_meta_q   <= vs;
            vs_sync_q   <= vs_meta_q;
            vs_hist_q   <= vs_sync_q;
            frame_evt_q <= frame_evt_d;
            jump_prev_q <= jump;
            frame_cnt_q <= frame_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            night_cnt_q <= night_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            level_q     <= level_d;
            night_q     <= night_d;
            flash_q     <= flash_d;
            tick_q      <= tick_d;
            clear_q     <= clear_d;
            running_q   <= running_d;
            game_over_q <= game_over_d;
        end
    end

    always_comb begin
        frame_evt_d = vs_hist_q & ~vs_sync_q;
        jump_rise   = jump & ~jump_prev_q;
        level_ext   = {2'b00, level_q};
        if (level_ext + FM5 >= FI5) fpt = 4'(FM5);
        else                        fpt = 4'(FI5 - level_ext);

        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        night_cnt_d = night_cnt_q;
        flash_cnt_d = flash_cnt_q;
        level_d     = level_q;
        night_d     = night_q;
        flash_d     = flash_q;
        tick_d      = 1'b0;
        clear_d     = 1'b0;

        if (!start) begin
            state_d = ST_IDLE;
            flash_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (jump_rise) begin
                        state_d     = ST_RUN;
                        clear_d     = 1'b1;
                        frame_cnt_d = '0;
                        tick_cnt_d  = '0;
                        night_cnt_d = '0;
                        level_d     = '0;
                        night_d     = 1'b0;
                    end
                end
                ST_RUN: begin
                    // Collision outranks a tick falling due in the same cycle.
                    if (collision) begin
                        state_d     = ST_FLASH;
                        flash_d     = 1'b1;
                        flash_cnt_d = '0;
                    end else if (frame_evt_q) begin
                        if (frame_cnt_q >= fpt - 4'd1) begin
                            tick_d      = 1'b1;
                            frame_cnt_d = '0;
                            if (tick_cnt_q == LT_LAST) begin
                                tick_cnt_d = '0;
                                if (level_q != 3'd7) level_d = level_q + 3'd1;
                            end else begin
                                tick_cnt_d = tick_cnt_q + 16'd1;
                            end
                            if (night_cnt_q == NT_LAST) begin
                                night_cnt_d = '0;
                                night_d     = ~night_q;
                            end else begin
                                night_cnt_d = night_cnt_q + 16'd1;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 4'd1;
                        end
                    end
                end
                ST_FLASH: begin
                    if (frame_evt_q) begin
                        if (flash_cnt_q == FF_LAST) begin
                            state_d = ST_OVER;
                            flash_d = 1'b0;
                        end else begin
                            flash_cnt_d = flash_cnt_q + 8'd1;
                            if (flash_cnt_q[2:0] == 3'd7) flash_d = ~flash_q;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        running_d   = (state_d == ST_RUN);
        game_over_d = (state_d == ST_FLASH) || (state_d == ST_OVER);
    end

    assign tick      = tick_q;
    assign running   = running_q;
    assign game_over = game_over_q;
    assign clear     = clear_q;
    assign flash     = flash_q;
    assign level     = level_q;
    assign night     = night_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed round scenarios followed by random operations,
// each output checked against a frame/tick-level model of the game rules.
module tb_game_sequencer;

    localparam int FI = 4;
    localparam int FM = 2;
    localparam int LT = 2;
    localparam int FF = 10;
    localparam int NT = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLASH = 2;
    localparam int M_OVER  = 3;

    logic       clk = 1'b0;
    logic       rstn, vs, start, jump, collision;
    logic       tick, running, game_over, clear, flash, night;
    logic [2:0] level;

    game_sequencer #(
        .FRAMES_INIT (FI),
        .FRAMES_MIN  (FM),
        .LEVEL_TICKS (LT),
        .FLASH_FRAMES(FF),
        .NIGHT_TICKS (NT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .vs       (vs),
        .start    (start),
        .jump     (jump),
        .collision(collision),
        .tick     (tick),
        .running  (running),
        .game_over(game_over),
        .clear    (clear),
        .flash    (flash),
        .level    (level),
        .night    (night)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int tick_seen  = 0;

    always @(posedge clk) if (tick === 1'b1) tick_seen++;

    // Reference model state: round mode, frames since last tick, ticks this round.
    int m_mode     = M_IDLE;
    int m_frames   = 0;
    int m_ticks    = 0;
    int m_total    = 0;
    int m_flash_ev = 0;
    bit m_jump_prev = 1'b1;
    bit exp_tick   = 1'b0;
    bit exp_clear  = 1'b0;

    function automatic int cur_level();
        int l = m_ticks / LT;
        return (l > 7) ? 7 : l;
    endfunction

    function automatic int fpt_of(int lvl);
        int f = FI - lvl;
        return (f < FM) ? FM : f;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        bit exp_flash;
        exp_flash = (m_mode == M_FLASH) && (((m_flash_ev / 8) % 2) == 0);
        chk({tag, ".running"},   32'(running),   32'(m_mode == M_RUN));
        chk({tag, ".game_over"}, 32'(game_over), 32'(m_mode == M_FLASH || m_mode == M_OVER));
        chk({tag, ".flash"},     32'(flash),     32'(exp_flash));
        chk({tag, ".level"},     32'(level),     32'(cur_level()));
        chk({tag, ".night"},     32'(night),     32'((m_ticks / NT) % 2));
        chk({tag, ".tick"},      32'(tick),      32'(exp_tick));
        chk({tag, ".clear"},     32'(clear),     32'(exp_clear));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(int n);
        repeat (n) begin
            cyc();
            check_all("idle");
        end
    endtask

    task automatic press_jump();
        jump = 1'b1;
        if (!m_jump_prev && start && (m_mode == M_IDLE || m_mode == M_OVER)) begin
            m_mode    = M_RUN;
            m_frames  = 0;
            m_ticks   = 0;
            exp_clear = 1'b1;
        end
        m_jump_prev = 1'b1;
        cyc();
        check_all("jump_press");
        exp_clear = 1'b0;
        cyc();
        check_all("jump_after");
    endtask

    task automatic release_jump();
        jump = 1'b0;
        m_jump_prev = 1'b0;
        cyc();
        check_all("jump_release");
    endtask

    task automatic set_start(bit v);
        start = v;
        if (!v) m_mode = M_IDLE;
        cyc();
        check_all("start");
    endtask

    task automatic collide();
        collision = 1'b1;
        if (m_mode == M_RUN) begin
            m_mode     = M_FLASH;
            m_flash_ev = 0;
        end
        cyc();
        check_all("collide");
        collision = 1'b0;
    endtask

    // One vsync pulse; the event reaches the FSM three edges after the fall is sampled.
    task automatic frame(bit coll);
        vs = 1'b0;
        repeat (3) begin
            cyc();
            check_all("frame_wait");
        end
        collision = coll;
        if (m_mode == M_RUN) begin
            if (coll) begin
                m_mode     = M_FLASH;
                m_flash_ev = 0;
            end else begin
                m_frames++;
                if (m_frames == fpt_of(cur_level())) begin
                    m_frames = 0;
                    m_ticks++;
                    m_total++;
                    exp_tick = 1'b1;
                end
            end
        end else if (m_mode == M_FLASH) begin
            m_flash_ev++;
            if (m_flash_ev == FF) m_mode = M_OVER;
        end
        cyc();
        check_all("frame_evt");
        collision = 1'b0;
        exp_tick  = 1'b0;
        vs        = 1'b1;
        cyc();
        check_all("frame_post");
        cyc();
        cyc();
    endtask

    initial begin
        rstn = 1'b0; vs = 1'b1; start = 1'b1; jump = 1'b1; collision = 1'b0;
        cyc();
        cyc();
        check_all("reset");
        rstn = 1'b1;
        idle_cycles(2);

        release_jump();
        press_jump();
        release_jump();
        repeat (12) frame(1'b0);

        for (int i = 0; i < 16 && m_frames != fpt_of(cur_level()) - 1; i++) frame(1'b0);
        frame(1'b1);

        press_jump();
        repeat (FF) frame(1'b0);
        idle_cycles(3);
        release_jump();
        press_jump();
        release_jump();

        repeat (40) frame(1'b0);

        set_start(1'b0);
        repeat (2) frame(1'b0);
        set_start(1'b1);
        idle_cycles(2);
        press_jump();
        release_jump();

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: frame($urandom_range(0, 15) == 0);
                5:             press_jump();
                6:             release_jump();
                7:             set_start($urandom_range(0, 3) != 0);
                8:             collide();
                default:       idle_cycles($urandom_range(1, 3));
            endcase
        end

        chk("tick_total", 32'(tick_seen), 32'(m_total));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Central game-flow controller between the VGA timing generator and the game datapath.
- Derives a frame-locked game tick from VGA vsync, replacing the free-running divided game clock.
- Runs the round state machine (idle / running / crash flash / over) and owns score-clear, difficulty level and day/night scheduling.
- Its outputs drive the game logic, renderer, score counter and LEDs.

Parameters:
- FRAMES_INIT, 4: frames per tick at level 0 (1..15).
- FRAMES_MIN, 1: lower bound on frames per tick (1..FRAMES_INIT).
- LEVEL_TICKS, 512: running ticks per level increment (2..65535).
- FLASH_FRAMES, 60: length of crash flash, in frames (1..255).
- NIGHT_TICKS, 1024: running ticks between day/night toggles (2..65535).

Ports:
- clk, in, 1: system clock.
- rstn, in, 1: synchronous reset, active-low.
- vs, in, 1: VGA vsync from timing generator, active-low, asynchronous to clk.
- start, in, 1: game enable level (switch); 0 forces idle.
- jump, in, 1: debounced jump button, active-high level.
- collision, in, 1: collision flag from game datapath, level.
- tick, out, 1: one-cycle game-step strobe.
- running, out, 1: high in RUN.
- game_over, out, 1: high in FLASH and OVER.
- clear, out, 1: one-cycle score/datapath clear strobe.
- flash, out, 1: crash blink for renderer.
- level, out, 3: difficulty level, saturates at 7.
- night, out, 1: night palette select.

Behaviour:
- Reset: rstn low at a clk edge sets state IDLE. All outputs 0. All counters 0. vs synchroniser stages set to 1. Reset has priority over every other event, including mid-round.
- vs handling: two-flop synchroniser plus one history flop. frame_evt is high for one cycle when synced vs goes 1->0. If vs falls before edge N, frame_evt is high in the cycle after edge N+2. Registered outputs appear at edge N+3.
- Jump edge: jump_rise = jump & ~jump_d, where jump_d is a registered copy.
- FSM, evaluated in this priority order:
  - start==0: go to IDLE from any state. No clear pulse.
  - IDLE: go to RUN on jump_rise. Pulse clear the same edge.
  - RUN: go to FLASH on collision==1, sampled at every edge. A tick due in that same cycle is suppressed.
  - FLASH: count frame_evt. After FLASH_FRAMES events, go to OVER.
  - OVER: go to RUN on jump_rise. Pulse clear.
- Entering RUN (clear cycle): reset frame counter, tick counter, night counter, level and night to 0.
- Tick generation, RUN only:
  - fpt = max(FRAMES_INIT - level, FRAMES_MIN), 4-bit.
  - Each frame_evt increments the frame counter.
  - When the counter equals fpt-1 at a frame_evt, pulse tick and reset the counter to 0.
  - The first tick after entering RUN is on the fpt-th frame_evt.
  - tick is never high outside RUN, and never in the same cycle as clear.
- Level: the tick counter counts ticks. At LEVEL_TICKS-1 it wraps to 0 and level increments. At 7, level stays 7 and the counter keeps wrapping.
- Night: a separate counter wraps at NIGHT_TICKS-1 and toggles night. Night is frozen outside RUN and cleared on clear.
- Flash:
  - flash toggles every 8 frame_evts in FLASH, starting at 1 on FLASH entry.
  - flash is 0 in IDLE, RUN and OVER.
- running = (state==RUN). game_over = (state==FLASH or OVER). Both are registered and change on the transition edge.
- Simultaneous events:
  - collision and frame_evt in the same RUN cycle: FLASH wins, no tick.
  - jump_rise and start==0: IDLE wins.
  - Jump held through OVER: no restart until it is released and pressed again.

Test Plan:
- Reset with rstn=0 for 2 cycles while start=1 and jump=1 -> every output 0, state IDLE. After release, no transition until a fresh jump rising edge.
- FRAMES_INIT=4, start=1, jump pulse, then 12 vs falls -> clear pulses 1 cycle. tick appears on frame_evts 4, 8 and 12. Each tick lands 3 clk after its vs fall sample edge. running=1 throughout.
- LEVEL_TICKS=4, FRAMES_INIT=4, FRAMES_MIN=2:
  - level reads 1 after the 4th tick.
  - fpt becomes 3.
  - After 4 more ticks, level reads 2 and fpt is clamped at 2.
  - With LEVEL_TICKS=2, level holds at 7 after the 14th tick.
- Collision in the same cycle as a due tick -> no tick, game_over=1 and flash=1 on the next edge. With FLASH_FRAMES=4, go to OVER after 4 frame_evts and flash returns to 0. Jump edge in OVER -> clear pulse, running=1, level=0, night=0.
- NIGHT_TICKS=3 -> night toggles after ticks 3 and 6. Drop start to 0 mid-RUN -> IDLE next edge, tick stops, night holds its value.
- Hold jump high from FLASH into OVER -> stays in OVER. Release and re-press -> RUN with exactly one clear pulse.
